// File: rtl/mips32_fetch_unit.sv
// mips32_fetch_unit: handshaked instruction fetch stage for the single-cycle
// MIPS32 datapath. Owns the PC, fetches one word per instruction, holds it
// until consumed and computes the next PC from the branch/jump outcome.
// Optional feature macro: FETCH_TIMEOUT_EN (imem_ack timeout, sticky fetch_err,
// terminal ERROR state). Without it fetch waits indefinitely and fetch_err=0.
module mips32_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_imm32,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic        fetch_err
);

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`else
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    VALID = 2'd1
  } state_t;
`endif

  state_t      state;
  state_t      state_next;

  // Held low through reset and for the first cycle after release, so the
  // request never depends combinationally on rst_n and a late ack from before
  // reset lands while imem_req=0 and is ignored.
  logic        armed;

  logic        capture;
  logic        consume;
  logic        timeout;

  logic [31:0] pc4;
  logic [31:0] branch_pc;
  logic [31:0] jump_pc;
  logic [31:0] next_pc;

`ifdef FETCH_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
`endif

  assign imem_req    = (state == FETCH) && armed;
  assign imem_addr   = pc;
  assign instr_valid = (state == VALID);

  // Next-PC selection: jump has priority over a taken branch.
  always_comb begin
    pc4       = pc + 32'd4;
    branch_pc = pc4 + {branch_imm32[29:0], 2'b00};
    jump_pc   = {pc4[31:28], jump_target, 2'b00};
    next_pc   = pc4;
    if (jump) begin
      next_pc = jump_pc;
    end else if (branch_taken) begin
      next_pc = branch_pc;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and handshake strobes; an ack wins over a same-cycle timeout.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    consume    = 1'b0;
    timeout    = 1'b0;
    case (state)
      FETCH: begin
        if (imem_req && imem_ack) begin
          capture    = 1'b1;
          state_next = VALID;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (imem_req && (wait_cnt == CNT_LAST)) begin
          timeout    = 1'b1;
          state_next = ERROR;
        end
`endif
      end
      VALID: begin
        if (instr_ready) begin
          consume    = 1'b1;
          state_next = FETCH;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      ERROR: begin
        state_next = ERROR;
      end
`endif
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // Request enable, set once on the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // Instruction holding register, loaded only on an accepted ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instruction <= '0;
    end else if (capture) begin
      instruction <= imem_rdata;
    end
  end

  // PC register, advanced only when the datapath consumes the instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (consume) begin
      pc <= next_pc;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Wait counter: cleared on entry to FETCH, counts requesting cycles without ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (consume) begin
      wait_cnt <= '0;
    end else if (imem_req && !imem_ack && !timeout) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
  logic unused_timeout;
  assign unused_timeout = timeout;
`endif

endmodule

// File: tb/tb_mips32_fetch_unit.sv
// tb_mips32_fetch_unit: directed self-checking bench for mips32_fetch_unit.
module tb_mips32_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_imm32;
  logic        jump;
  logic [25:0] jump_target;
  logic        fetch_err;

  int unsigned checks;
  int unsigned errors;

  mips32_fetch_unit #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instruction  (instruction),
    .pc           (pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_taken (branch_taken),
    .branch_imm32 (branch_imm32),
    .jump         (jump),
    .jump_target  (jump_target),
    .fetch_err    (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Return a word on the current request, then drop ack.
  task automatic deliver(input logic [31:0] data);
    imem_ack   = 1'b1;
    imem_rdata = data;
    step();
    imem_ack   = 1'b0;
  endtask

  // Consume the presented instruction with the given branch/jump outcome.
  task automatic consume(input logic bt, input logic [31:0] imm, input logic jmp,
                         input logic [25:0] tgt);
    branch_taken = bt;
    branch_imm32 = imm;
    jump         = jmp;
    jump_target  = tgt;
    instr_ready  = 1'b1;
    step();
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    jump         = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b1;
    imem_ack     = 1'b0;
    imem_rdata   = '0;
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    branch_imm32 = '0;
    jump         = 1'b0;
    jump_target  = '0;
    #1 rst_n = 1'b0;
    step();
    step();

    // Reset state
    chk ("rst_pc",    pc,          32'h0);
    chk ("rst_instr", instruction, 32'h0);
    chk1("rst_valid", instr_valid, 1'b0);
    chk1("rst_req",   imem_req,    1'b0);
    chk1("rst_err",   fetch_err,   1'b0);

    rst_n = 1'b1;
    step();

    // Same-cycle acks, always ready: 0,4,8,C on alternating cycles
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk1("t1_req",   imem_req,  1'b1);
      chk ("t1_addr",  imem_addr, 32'(i * 4));
      chk ("t1_pc",    pc,        32'(i * 4));
      imem_rdata = 32'h1000_0000 + 32'(i);
      step();
      chk1("t1_valid", instr_valid, 1'b1);
      chk ("t1_instr", instruction, 32'h1000_0000 + 32'(i));
      chk1("t1_req_lo", imem_req,   1'b0);
      chk ("t1_vpc",   pc,          32'(i * 4));
      step();
    end
    imem_ack = 1'b0;

    // Ack delayed 3 cycles: request held 4 cycles at 0x10
    for (int k = 0; k < 3; k++) begin
      chk1("t2_req",   imem_req,    1'b1);
      chk ("t2_addr",  imem_addr,   32'h10);
      chk1("t2_valid", instr_valid, 1'b0);
      step();
    end
    chk1("t2_req4",  imem_req,  1'b1);
    chk ("t2_addr4", imem_addr, 32'h10);
    deliver(32'hDEAD_BEEF);
    chk1("t2_valid_after", instr_valid, 1'b1);
    chk ("t2_instr",       instruction, 32'hDEAD_BEEF);

    // Consumer stall: 5 cycles, branch/jump inputs toggling but ignored
    instr_ready  = 1'b0;
    branch_taken = 1'b1;
    jump         = 1'b1;
    jump_target  = 26'h3FF_FFFF;
    branch_imm32 = 32'h0000_0100;
    for (int k = 0; k < 5; k++) begin
      step();
      chk ("t4_instr", instruction, 32'hDEAD_BEEF);
      chk ("t4_pc",    pc,          32'h10);
      chk1("t4_req",   imem_req,    1'b0);
      chk1("t4_valid", instr_valid, 1'b1);
    end
    // Both branch and jump on consume: jump wins -> 0x40 (branch would be 0x414)
    consume(1'b1, 32'h0000_0100, 1'b1, 26'h10);
    chk ("t4_jpc",   pc,          32'h40);
    chk ("t4_jaddr", imem_addr,   32'h40);
    chk1("t4_jreq",  imem_req,    1'b1);
    chk1("t4_jval",  instr_valid, 1'b0);

    // Branch back by -2 words: 0x44 - 8 = 0x3C
    deliver(32'h1234_5678);
    chk ("t3_instr", instruction, 32'h1234_5678);
    consume(1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0);
    chk ("t3_bpc",   pc,        32'h3C);
    chk ("t3_baddr", imem_addr, 32'h3C);
    // Jump to word 0x10 -> 0x40
    deliver(32'h0800_0010);
    consume(1'b0, 32'h0, 1'b1, 26'h10);
    chk ("t3_jpc",   pc,        32'h40);

    // Wraparound: 0x44 - 72 = 0xFFFFFFFC, then pc4 wraps to 0
    deliver(32'h1111_1111);
    consume(1'b1, 32'hFFFF_FFEE, 1'b0, 26'h0);
    chk ("wr_bpc",  pc, 32'hFFFF_FFFC);
    deliver(32'h2222_2222);
    consume(1'b0, 32'h0, 1'b0, 26'h0);
    chk ("wr_pc4",  pc, 32'h0);
    deliver(32'h3333_3333);
    consume(1'b1, 32'hFFFF_FFFE, 1'b0, 26'h0);
    chk ("wr_bpc2", pc, 32'hFFFF_FFFC);
    // Jump region comes from pc4 (0) not pc (F...)
    deliver(32'h4444_4444);
    consume(1'b0, 32'h0, 1'b1, 26'h3FF_FFFF);
    chk ("wr_jpc",  pc, 32'h0FFF_FFFC);

    // instr_ready while not valid has no effect
    consume(1'b1, 32'h0000_0100, 1'b1, 26'h1);
    chk ("rdy_noval_pc",  pc,          32'h0FFF_FFFC);
    chk1("rdy_noval_req", imem_req,    1'b1);
    chk1("rdy_noval_val", instr_valid, 1'b0);

    // Reset mid-FETCH, stray ack during reset and before the new request
    step();
    rst_n = 1'b0;
    #1;
    chk ("r5_pc",    pc,          32'h0);
    chk1("r5_valid", instr_valid, 1'b0);
    chk1("r5_req",   imem_req,    1'b0);
    chk ("r5_instr", instruction, 32'h0);
    imem_ack   = 1'b1;
    imem_rdata = 32'hBAD0_BAD0;
    step();
    rst_n = 1'b1;
    step();
    imem_ack = 1'b0;
    chk1("r5_valid2", instr_valid, 1'b0);
    chk ("r5_instr2", instruction, 32'h0);
    chk1("r5_req2",   imem_req,    1'b1);
    chk ("r5_addr2",  imem_addr,   32'h0);
    step();
    chk1("r5_valid3", instr_valid, 1'b0);
    chk ("r5_instr3", instruction, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    // One no-ack FETCH cycle so far; 14 more keep the count below 16
    for (int k = 0; k < 14; k++) begin
      step();
      chk1("to_err_lo", fetch_err, 1'b0);
      chk1("to_req_hi", imem_req,  1'b1);
    end
    step();
    chk1("to_err",   fetch_err,   1'b1);
    chk1("to_req",   imem_req,    1'b0);
    chk1("to_valid", instr_valid, 1'b0);
    imem_ack = 1'b1;
    step();
    step();
    imem_ack = 1'b0;
    chk1("to_err_sticky", fetch_err,   1'b1);
    chk1("to_req_stay",   imem_req,    1'b0);
    chk1("to_valid_stay", instr_valid, 1'b0);
`else
    // No timeout: fetch keeps waiting
    repeat (20) step();
    chk1("nt_req",   imem_req,    1'b1);
    chk ("nt_addr",  imem_addr,   32'h0);
    chk1("nt_err",   fetch_err,   1'b0);
    chk1("nt_valid", instr_valid, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
